// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencing controller: FSM state
// encoding, opcode constants, ALU-op and trap-cause encodings, and the
// Moore decode of the per-state control word.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WB, S_MEM_WR, S_ALU_WB, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Control outputs that depend on the state alone (registered in the top).
    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       trap;
    } ctl_t;

    function automatic ctl_t moore_decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = ALU_ADD;
            end
            S_DECODE:   begin c.alu_src_b = 2'b10; c.alu_op = ALU_ADD; end
            S_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; c.alu_op = ALU_FUNCT; end
            S_EXEC_I:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = ALU_FUNCT; end
            S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = ALU_ADD; end
            S_MEM_RD:   begin c.mem_req = 1'b1; c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEM_WR:   begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.iord = 1'b1; end
            S_ALU_WB:   c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; c.alu_op = ALU_SUB; c.pc_src = 1'b1;
            end
            S_JAL:      begin c.pc_src = 1'b1; c.reg_write = 1'b1; end
            S_TRAP:     c.trap = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory handshake watchdog. Counts cycles spent waiting on an outstanding
// request and flags expiry once the count reaches MEM_TIMEOUT.
//   clk, reset  : clock, async active-low reset
//   clear       : zero the count (ack seen or wait abandoned)
//   waiting     : a request is outstanding this cycle
//   expired     : count has reached MEM_TIMEOUT
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    output logic expired
);
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       cnt <= 8'd0;
        else if (clear)   cnt <= 8'd0;
        else if (waiting) cnt <= cnt + 8'd1;
    end

    assign expired = (cnt == 8'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle Moore sequencer for the RV32I-subset datapath. Steps each
// instruction through fetch/decode/execute/memory/writeback, drives the
// shared-memory request handshake, traps on illegal opcodes or memory
// timeout, and counts retired instructions.
//   inputs : clk, reset (async low), opcode, funct3, zero, mem_ack
//   outputs: memory handshake (mem_req/read/write, iord), datapath enables
//            and muxes, trap/trap_cause, instret
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [INSTRET_W-1:0] instret
);
    state_t     state, nxt;
    ctl_t       ctl;
    logic [1:0] cause_q, cause_nxt;
    logic       armed, retire, expired, br_legal, br_take;

    // Every exit from a wait state is either an ack or an expiry, so clearing
    // on those two events also resets the count on each state entry.
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (mem_ack | expired),
        .waiting (ctl.mem_req),
        .expired (expired)
    );

    assign br_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign br_take  = (funct3 == 3'b000) ? zero : ((funct3 == 3'b001) ? !zero : 1'b0);

    always_comb begin
        nxt       = state;
        cause_nxt = cause_q;
        retire    = 1'b0;
        case (state)
            S_IDLE:   if (armed) nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ack)      nxt = S_DECODE;
                else if (expired) begin nxt = S_TRAP; cause_nxt = CAUSE_TIMEOUT; end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:               nxt = S_EXEC_R;
                    OP_I:               nxt = S_EXEC_I;
                    OP_LOAD, OP_STORE:  nxt = S_MEM_ADDR;
                    OP_BRANCH:          nxt = S_BRANCH;
                    OP_JAL:             nxt = S_JAL;
                    default: begin nxt = S_TRAP; cause_nxt = CAUSE_ILLEGAL; end
                endcase
            end
            S_EXEC_R, S_EXEC_I: nxt = S_ALU_WB;
            S_MEM_ADDR: nxt = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ack)      nxt = S_MEM_WB;
                else if (expired) begin nxt = S_TRAP; cause_nxt = CAUSE_TIMEOUT; end
            end
            S_MEM_WR: begin
                if (mem_ack)      begin nxt = S_FETCH; retire = 1'b1; end
                else if (expired) begin nxt = S_TRAP; cause_nxt = CAUSE_TIMEOUT; end
            end
            S_ALU_WB, S_MEM_WB, S_JAL: begin nxt = S_FETCH; retire = 1'b1; end
            S_BRANCH: begin
                if (br_legal) begin nxt = S_FETCH; retire = 1'b1; end
                else          begin nxt = S_TRAP; cause_nxt = CAUSE_ILLEGAL; end
            end
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_IDLE;
        endcase
    end

    // armed delays the IDLE->FETCH step by one edge so the first fetch lands
    // on the second rising edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            ctl     <= '0;
            cause_q <= CAUSE_NONE;
            armed   <= 1'b0;
            instret <= '0;
        end else begin
            state   <= nxt;
            ctl     <= moore_decode(nxt);
            cause_q <= cause_nxt;
            armed   <= 1'b1;
            if (retire) instret <= instret + INSTRET_W'(1);
        end
    end

    assign mem_req    = ctl.mem_req;
    assign mem_read   = ctl.mem_read;
    assign mem_write  = ctl.mem_write;
    assign iord       = ctl.iord;
    assign pc_src     = ctl.pc_src;
    assign alu_src_a  = ctl.alu_src_a;
    assign alu_src_b  = ctl.alu_src_b;
    assign alu_op     = ctl.alu_op;
    assign reg_write  = ctl.reg_write;
    assign mem_to_reg = ctl.mem_to_reg;
    assign trap       = ctl.trap;
    assign trap_cause = cause_q;

    // Same-cycle gated enables: fetch completes on ack, branch writes PC on taken.
    assign ir_write = (state == S_FETCH) && mem_ack;
    assign pc_write = ir_write || (state == S_JAL) || ((state == S_BRANCH) && br_take);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised bench for multicycle_ctrl. Each instruction is expanded into a
// per-cycle list of required outputs and mem_ack stimulus from the cycle
// recipe of its class; one compare process checks every cycle.
module tb_multicycle_ctrl;
    logic       clk = 1'b0, reset = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0, mem_ack = 1'b0;
    logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0] alu_src_b, alu_op, trap_cause;
    logic       reg_write, mem_to_reg, trap;
    logic [3:0] instret;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .INSTRET_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .trap(trap),
        .trap_cause(trap_cause), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       reg_write, mem_to_reg, trap;
        logic [1:0] trap_cause;
        logic [3:0] instret;
    } row_t;

    typedef struct packed {
        row_t       e;
        logic       ack, dc;   // dc: mem_ack is irrelevant, drive it randomly
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
    } step_t;

    int         total = 0, bad = 0, rown = 0;
    row_t       expq[$];
    step_t      plan[$];
    logic [3:0] im = '0;        // model retired count (mod 16)
    logic [6:0] cur_op = '0;
    logic [2:0] cur_f3 = '0;
    logic       cur_z = 1'b0;
    row_t       act, ce;

    assign act = {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, alu_op, reg_write, mem_to_reg, trap, trap_cause, instret};

    initial forever begin
        @(negedge clk);
        if (expq.size() > 0) begin
            ce = expq.pop_front();
            total++; rown++;
            if (act !== ce) begin
                bad++;
                $display("FAIL cycle_row%0d got=%h want=%h", rown, act, ce);
            end
        end
    end

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", n, a, e);
        end
    endtask

    function automatic row_t blank();
        row_t r;
        r = '0;
        r.instret = im;
        return r;
    endfunction

    task automatic push(input row_t r, input logic ack, input logic dc);
        step_t s;
        s.e = r; s.ack = ack; s.dc = dc; s.op = cur_op; s.f3 = cur_f3; s.z = cur_z;
        plan.push_back(s);
    endtask

    task automatic g_fetch(input int d);
        row_t r;
        r = blank(); r.mem_req = 1; r.mem_read = 1; r.alu_src_b = 2'b01;
        for (int i = 0; i < d; i++) push(r, 1'b0, 1'b0);
        r.ir_write = 1; r.pc_write = 1;
        push(r, 1'b1, 1'b0);
    endtask

    task automatic g_decode();
        row_t r;
        r = blank(); r.alu_src_b = 2'b10;
        push(r, 1'b0, 1'b1);
    endtask

    task automatic g_trap(input int n, input logic [1:0] cause);
        row_t r;
        r = blank(); r.trap = 1; r.trap_cause = cause;
        for (int i = 0; i < n; i++) push(r, 1'b0, 1'b1);
    endtask

    task automatic g_addr();
        row_t r;
        r = blank(); r.alu_src_a = 1; r.alu_src_b = 2'b10;
        push(r, 1'b0, 1'b1);
    endtask

    // kind: 0 R, 1 I, 2 load, 3 store, 4 branch, 5 jal, 6 illegal opcode
    task automatic gen_instr(input int kind, input logic [2:0] f3, input logic z,
                             input int df, input int dm);
        row_t r;
        cur_z  = z;
        cur_f3 = (kind == 4) ? f3 : 3'($urandom);
        case (kind)
            0: cur_op = 7'b0110011;  1: cur_op = 7'b0010011;
            2: cur_op = 7'b0000011;  3: cur_op = 7'b0100011;
            4: cur_op = 7'b1100011;  5: cur_op = 7'b1101111;
            default: cur_op = 7'b1111111;
        endcase
        g_fetch(df);
        g_decode();
        case (kind)
            0, 1: begin
                r = blank(); r.alu_src_a = 1; r.alu_op = 2'b10;
                r.alu_src_b = (kind == 0) ? 2'b00 : 2'b10;
                push(r, 1'b0, 1'b1);
                r = blank(); r.reg_write = 1; push(r, 1'b0, 1'b1);
                im++;
            end
            2: begin
                g_addr();
                r = blank(); r.mem_req = 1; r.mem_read = 1; r.iord = 1;
                for (int i = 0; i < dm; i++) push(r, 1'b0, 1'b0);
                push(r, 1'b1, 1'b0);
                r = blank(); r.reg_write = 1; r.mem_to_reg = 1; push(r, 1'b0, 1'b1);
                im++;
            end
            3: begin
                g_addr();
                r = blank(); r.mem_req = 1; r.mem_write = 1; r.iord = 1;
                for (int i = 0; i < dm; i++) push(r, 1'b0, 1'b0);
                push(r, 1'b1, 1'b0);
                im++;
            end
            4: begin
                r = blank(); r.alu_src_a = 1; r.alu_op = 2'b01; r.pc_src = 1;
                r.pc_write = (f3 == 3'd0) ? z : ((f3 == 3'd1) ? !z : 1'b0);
                push(r, 1'b0, 1'b1);
                if (f3 < 3'd2) im++;
                else g_trap(5, 2'b01);
            end
            5: begin
                r = blank(); r.pc_src = 1; r.pc_write = 1; r.reg_write = 1;
                push(r, 1'b0, 1'b1);
                im++;
            end
            default: g_trap(20, 2'b01);
        endcase
    endtask

    task automatic drive_step(input step_t s);
        opcode  = s.op;
        funct3  = s.f3;
        zero    = s.z;
        mem_ack = s.dc ? 1'($urandom) : s.ack;
        expq.push_back(s.e);
        @(posedge clk); #1;
    endtask

    task automatic run_plan();
        while (plan.size() > 0) drive_step(plan.pop_front());
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("reset_async_mem_req", int'(mem_req), 0);
        im = '0;
        push(blank(), 1'b0, 1'b1); push(blank(), 1'b0, 1'b1);
        run_plan();
        reset = 1'b1;
        push(blank(), 1'b0, 1'b1); push(blank(), 1'b0, 1'b1);
        run_plan();
    endtask

    initial begin
        row_t r;
        @(posedge clk); #1;
        do_reset();

        // R-type, zero-wait: 4 cycles, instret 0 -> 1
        gen_instr(0, 3'd0, 1'b0, 0, 0);
        chk("rtype_cycles", plan.size(), 4);
        run_plan();
        chk("rtype_instret", int'(instret), 1);

        // load, 3 wait cycles in both fetch and memory read: 11 cycles
        gen_instr(2, 3'd0, 1'b0, 3, 3);
        chk("load_cycles", plan.size(), 11);
        run_plan();
        chk("load_instret", int'(instret), 2);

        gen_instr(3, 3'd0, 1'b0, 0, 0);
        chk("store_cycles", plan.size(), 4);
        run_plan();
        gen_instr(4, 3'd0, 1'b1, 0, 0);
        chk("branch_cycles", plan.size(), 3);
        run_plan();

        // random mix, delays up to the ack-wins boundary
        for (int n = 0; n < 40; n++) begin
            gen_instr(int'($urandom_range(0, 5)), 3'($urandom_range(0, 1)), 1'($urandom),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
            run_plan();
        end

        // beq / bne truth table
        gen_instr(4, 3'd0, 1'b1, 0, 0); gen_instr(4, 3'd0, 1'b0, 1, 0);
        gen_instr(4, 3'd1, 1'b1, 0, 0); gen_instr(4, 3'd1, 1'b0, 2, 0);
        run_plan();

        // ack in the cycle the count reaches the limit: no trap
        gen_instr(0, 3'd0, 1'b0, 4, 0); gen_instr(2, 3'd0, 1'b0, 0, 4);
        gen_instr(3, 3'd0, 1'b0, 4, 4);
        run_plan();

        // illegal branch funct3
        gen_instr(4, 3'd2, 1'b1, 0, 0);
        run_plan();
        chk("bad_funct3_trap", int'(trap), 1);
        chk("bad_funct3_cause", int'(trap_cause), 1);
        do_reset();

        // illegal opcode: trapped for 20 cycles, instret frozen
        gen_instr(0, 3'd0, 1'b0, 0, 0);
        gen_instr(6, 3'd0, 1'b0, 1, 0);
        run_plan();
        chk("illegal_cause", int'(trap_cause), 1);
        chk("illegal_instret", int'(instret), 1);
        do_reset();

        // fetch never acknowledged: timeout trap
        cur_op = 7'b0110011;
        r = blank(); r.mem_req = 1; r.mem_read = 1; r.alu_src_b = 2'b01;
        for (int i = 0; i < 5; i++) push(r, 1'b0, 1'b0);
        g_trap(6, 2'b10);
        run_plan();
        chk("timeout_cause", int'(trap_cause), 2);
        do_reset();

        // reset pulsed while a store waits
        cur_op = 7'b0100011;
        g_fetch(0); g_decode(); g_addr();
        r = blank(); r.mem_req = 1; r.mem_write = 1; r.iord = 1;
        push(r, 1'b0, 1'b0); push(r, 1'b0, 1'b0);
        run_plan();
        chk("mid_store_mem_write", int'(mem_write), 1);
        do_reset();
        chk("post_reset_instret", int'(instret), 0);

        // counter wrap at 4 bits
        for (int i = 0; i < 15; i++) gen_instr(5, 3'd0, 1'b0, 0, 0);
        run_plan();
        chk("instret_all_ones", int'(instret), 15);
        gen_instr(5, 3'd0, 1'b0, 0, 0);
        run_plan();
        chk("instret_wrap", int'(instret), 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the RV32I-subset CPU datapath: register file, ALU with ALU-control decoder, PC register and a single shared instruction/data memory. Replaces the single-cycle combinational `control` decode with a Moore FSM. The FSM steps each instruction through fetch, decode, execute, memory and writeback. It runs a request/acknowledge handshake toward the shared memory, watches that handshake for timeout, and counts retired instructions.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles for `mem_ack` before a trap (1..255).
- INSTRET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  7  instruction register bits [6:0]
- funct3  in  3  instruction register bits [14:12]
- zero  in  1  ALU zero flag
- mem_ack  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_read  out  1  read access (valid with mem_req)
- mem_write  out  1  write access (valid with mem_req)
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut
- alu_src_a  out  1  0 = PC, 1 = rs1
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate
- alu_op  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- trap  out  1  controller halted
- trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout
- instret  out  INSTRET_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JAL, TRAP.
- IDLE: all outputs 0. Unconditionally goes to FETCH.
- FETCH: mem_req=1, mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - Without mem_ack: stays in FETCH.
  - In the mem_ack cycle: ir_write=1 and pc_write=1 (PC+4), then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut). Dispatch on opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode -> TRAP with cause 01
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=10. Goes to ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0. Retires; goes to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_req=1, mem_read=1, iord=1. Holds until mem_ack, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1. Retires; goes to FETCH.
- MEM_WR: mem_req=1, mem_write=1, iord=1. Holds until mem_ack, then retires and goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1.
  - pc_write = zero when funct3=000 (beq).
  - pc_write = !zero when funct3=001 (bne).
  - Any other funct3 -> TRAP with cause 01.
  - Otherwise retires; goes to FETCH.
- JAL: pc_src=1, pc_write=1, reg_write=1, mem_to_reg=0. Retires; goes to FETCH.
- TRAP: all outputs 0 except trap=1 and trap_cause. Held until reset; mem_ack is ignored.
- Timeout counter (8-bit):
  - Clears on every state entry and on mem_ack.
  - Increments each cycle that mem_req=1 and mem_ack=0.
  - Reaching MEM_TIMEOUT -> TRAP with cause 10 on the next edge.
  - If mem_ack arrives in the same cycle the count hits MEM_TIMEOUT, mem_ack wins and no trap occurs.
- instret increments by 1 on each retire edge. It wraps from all-ones to 0.

## Timing
- Reset asserted: state becomes IDLE, instret 0, timeout counter 0, trap 0, trap_cause 00, every control output 0. This holds from any state, including mid-handshake; an outstanding request is dropped.
- First FETCH is the second rising edge after reset is released.
- Outputs are Moore decodes of the state register, with three exceptions gated combinationally in the same cycle:
  - ir_write and pc_write in FETCH, by mem_ack
  - pc_write in BRANCH, by zero
- mem_req, mem_read, mem_write and iord stay stable for the whole wait. They drop the cycle after the ack edge.
- Cycles per instruction with zero-wait memory (mem_ack=1 in the first request cycle):
  - R-type and I-type: 4
  - load: 5
  - store: 4
  - branch and JAL: 3
- Each memory wait cycle adds 1.

## Structure
- Package cpu_ctrl_pkg holds:
  - state enum
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL)
  - alu_op encodings
  - trap_cause encodings
- Sub-module mem_wait_timer (parameter MEM_TIMEOUT; ports clk, reset, clear, waiting, expired) holds the timeout counter. The FSM and instret counter stay in multicycle_ctrl.

## Test plan
- R-type, opcode 0110011, mem_ack=1 on the first FETCH cycle -> states FETCH, DECODE, EXEC_R, ALU_WB. reg_write=1 in cycle 4; instret 0 -> 1.
- Load with mem_ack delayed 3 cycles in both FETCH and MEM_RD -> 11 cycles total; mem_req stable throughout each wait; mem_to_reg=1 in MEM_WB.
- beq: zero=1 gives pc_write=1 with pc_src=1; zero=0 gives pc_write=0. bne reverses both cases. funct3=010 -> trap=1, trap_cause=01.
- Opcode 1111111 -> TRAP with cause 01. All enables stay 0 for 20 cycles. instret unchanged.
- MEM_TIMEOUT=4 with mem_ack never asserted -> trap_cause=10 after 4 wait cycles. Repeat with mem_ack in exactly the 4th wait cycle -> no trap.
- Reset pulsed mid-MEM_WR -> all outputs 0 immediately. instret preset to all-ones, then one retire -> instret 0.
